// File: rtl/pc_sequencer.sv
// Next-PC controller for the MIPS-32 fetch stage: priority redirect select, hold and one-deep
// redirect buffer. Optional sticky target-alignment error output under `PC_ALIGN_CHECK_EN.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
   parameter int unsigned PC_STEP      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        fetch_ready,
   input  logic        exc_req,
   input  logic        jump_req,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        fetch_req,
   output logic [31:0] current_pc,
   output logic        redirect_taken,
   output logic        pending_valid
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic        misalign_err
`endif
);

   typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  pend_pri_q, pend_pri_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic        redir_q, redir_d;

   logic [1:0]  live_pri;
   logic [31:0] live_raw, live_tgt;
   logic        adv, live_wins, accept;

   // Priority encode: 3 = exception, 2 = jump, 1 = branch, 0 = none.
   always_comb begin
      live_pri = 2'd0;
      live_raw = 32'h0;
      if (exc_req) begin
         live_pri = 2'd3;
         live_raw = EXC_VECTOR;
      end else if (jump_req) begin
         live_pri = 2'd2;
         live_raw = jump_target;
      end else if (branch_taken) begin
         live_pri = 2'd1;
         live_raw = branch_target;
      end
   end

   assign live_tgt  = {live_raw[31:2], 2'b00};
   assign fetch_req = (state_q != StBoot);
   assign adv       = fetch_req & fetch_ready & ~stall;
   assign live_wins = (live_pri > pend_pri_q);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pri_d = pend_pri_q;
      pend_tgt_d = pend_tgt_q;
      redir_d    = 1'b0;
      accept     = 1'b0;
      unique case (state_q)
         StBoot: state_d = StRun;
         StRun: begin
            if (adv) begin
               if (live_pri != 2'd0) begin
                  pc_d    = live_tgt;
                  redir_d = 1'b1;
                  accept  = 1'b1;
               end else begin
                  pc_d = pc_q + 32'(PC_STEP);
               end
            end else if (live_pri != 2'd0) begin
               pend_pri_d = live_pri;
               pend_tgt_d = live_tgt;
               accept     = 1'b1;
               state_d    = StHold;
            end
         end
         StHold: begin
            if (live_wins) begin
               pend_pri_d = live_pri;
               pend_tgt_d = live_tgt;
               accept     = 1'b1;
            end
            // A live higher-priority redirect takes the slot in the same cycle it is released.
            if (adv) begin
               pc_d       = live_wins ? live_tgt : pend_tgt_q;
               redir_d    = 1'b1;
               pend_pri_d = 2'd0;
               pend_tgt_d = 32'h0;
               state_d    = StRun;
            end
         end
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StBoot;
         pc_q       <= RESET_VECTOR;
         pend_pri_q <= 2'd0;
         pend_tgt_q <= 32'h0;
         redir_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pri_q <= pend_pri_d;
         pend_tgt_q <= pend_tgt_d;
         redir_q    <= redir_d;
      end
   end

   assign current_pc     = pc_q;
   assign redirect_taken = redir_q;
   assign pending_valid  = (state_q == StHold);

`ifdef PC_ALIGN_CHECK_EN
   logic mis_q, mis_d;

   assign mis_d = mis_q | (accept & (|live_raw[1:0]));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
      end
   end

   assign misalign_err = mis_q;
`else
   logic unused_align;
   assign unused_align = ^{live_raw[1:0], accept};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, async-reset sequence and
// randomized traffic against a behavioural next-PC model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, fetch_ready, exc_req, jump_req, branch_taken;
   logic [31:0] jump_target, branch_target;
   logic        fetch_req, redirect_taken, pending_valid;
   logic [31:0] current_pc;
`ifdef PC_ALIGN_CHECK_EN
   logic        misalign_err;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pc_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .fetch_ready    (fetch_ready),
      .exc_req        (exc_req),
      .jump_req       (jump_req),
      .jump_target    (jump_target),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .fetch_req      (fetch_req),
      .current_pc     (current_pc),
      .redirect_taken (redirect_taken),
      .pending_valid  (pending_valid)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .misalign_err   (misalign_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        s, r, e, j;
      logic [31:0] jt;
      logic        b;
      logic [31:0] bt;
      logic [31:0] pc;
      logic        rd, pd, ms;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic s, input logic r, input logic e, input logic j,
                              input logic [31:0] jt, input logic b, input logic [31:0] bt,
                              input logic [31:0] pc, input logic rd, input logic pd,
                              input logic ms);
      vec_t t;
      t.s = s; t.r = r; t.e = e; t.j = j; t.jt = jt; t.b = b; t.bt = bt;
      t.pc = pc; t.rd = rd; t.pd = pd; t.ms = ms;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic r, input logic e, input logic j,
                        input logic [31:0] jt, input logic b, input logic [31:0] bt);
      stall = s; fetch_ready = r; exc_req = e; jump_req = j; jump_target = jt;
      branch_taken = b; branch_target = bt;
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic apply(input vec_t t, input string tag);
      drive(t.s, t.r, t.e, t.j, t.jt, t.b, t.bt);
      @(posedge clk);
      #1;
      chk({tag, " pc"}, current_pc, t.pc);
      chk({tag, " redirect_taken"}, {31'b0, redirect_taken}, {31'b0, t.rd});
      chk({tag, " pending_valid"}, {31'b0, pending_valid}, {31'b0, t.pd});
      chk({tag, " fetch_req"}, {31'b0, fetch_req}, 32'd1);
`ifdef PC_ALIGN_CHECK_EN
      chk({tag, " misalign_err"}, {31'b0, misalign_err}, {31'b0, t.ms});
`endif
      @(negedge clk);
   endtask

   // Reference model state
   int          m_mode;   // 0 boot, 1 run, 2 hold
   logic [31:0] m_pc, m_ptgt;
   int          m_ppri;
   logic        m_redir, m_mis;

   task automatic model_step(input logic s, input logic r, input logic e, input logic j,
                             input logic [31:0] jt, input logic b, input logic [31:0] bt);
      int          lp;
      logic [31:0] raw;
      logic        advance;
      lp  = e ? 3 : j ? 2 : b ? 1 : 0;
      raw = e ? 32'h80 : j ? jt : b ? bt : 32'h0;
      advance = (m_mode != 0) && r && !s;
      m_redir = 1'b0;
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (advance && lp != 0) begin
            m_pc = raw & ~32'h3; m_redir = 1'b1;
            if (raw % 4 != 0) m_mis = 1'b1;
         end else if (advance) begin
            m_pc = m_pc + 32'd4;
         end else if (lp != 0) begin
            m_ppri = lp; m_ptgt = raw & ~32'h3; m_mode = 2;
            if (raw % 4 != 0) m_mis = 1'b1;
         end
      end else begin
         if (lp > m_ppri) begin
            m_ppri = lp; m_ptgt = raw & ~32'h3;
            if (raw % 4 != 0) m_mis = 1'b1;
         end
         if (advance) begin
            m_pc = m_ptgt; m_redir = 1'b1; m_mode = 1; m_ppri = 0;
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
      repeat (3) @(negedge clk);
      chk("reset pc", current_pc, 32'h0);
      chk("reset fetch_req", {31'b0, fetch_req}, 32'd0);
      chk("reset redirect_taken", {31'b0, redirect_taken}, 32'd0);
      chk("reset pending_valid", {31'b0, pending_valid}, 32'd0);

      //           s  r  e  j  jt            b  bt            pc            rd pd ms
      tbl.push_back(v(0, 1, 0, 1, 32'h700,      0, 32'h0,      32'h0,        0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'h4,        0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'h8,        0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'hC,        0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'h10,       0, 0, 0));
      tbl.push_back(v(0, 1, 0, 1, 32'h200,      1, 32'h40,     32'h200,      1, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'h204,      0, 0, 0));
      tbl.push_back(v(0, 1, 0, 1, 32'h20,       0, 32'h0,      32'h20,       1, 0, 0));
      tbl.push_back(v(1, 1, 0, 0, 32'h0,        0, 32'h0,      32'h20,       0, 0, 0));
      tbl.push_back(v(1, 1, 0, 0, 32'h0,        1, 32'h100,    32'h20,       0, 1, 0));
      tbl.push_back(v(1, 1, 0, 1, 32'h300,      0, 32'h0,      32'h20,       0, 1, 0));
      tbl.push_back(v(1, 1, 0, 0, 32'h0,        0, 32'h0,      32'h20,       0, 1, 0));
      tbl.push_back(v(1, 1, 0, 0, 32'h0,        0, 32'h0,      32'h20,       0, 1, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'h300,      1, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'h304,      0, 0, 0));
      tbl.push_back(v(1, 1, 0, 0, 32'h0,        1, 32'h100,    32'h304,      0, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 32'h0,        0, 32'h0,      32'h304,      0, 1, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'h80,       1, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'h84,       0, 0, 0));
      tbl.push_back(v(0, 1, 0, 1, 32'hFFFF_FFF8, 0, 32'h0,     32'hFFFF_FFF8, 1, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'hFFFF_FFFC, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'h0,        0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,      32'h0,        0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h55,     32'h0,        0, 1, 1));
      tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h200,    32'h0,        0, 1, 1));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'h54,       1, 0, 1));
      tbl.push_back(v(1, 1, 0, 0, 32'h0,        1, 32'h10,     32'h54,       0, 1, 1));
      tbl.push_back(v(0, 1, 0, 1, 32'h500,      0, 32'h0,      32'h500,      1, 0, 1));
      tbl.push_back(v(1, 1, 1, 0, 32'h0,        0, 32'h0,      32'h500,      0, 1, 1));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'h900,    32'h80,       1, 0, 1));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,      32'h84,       0, 0, 1));

      @(negedge clk);
      reset = 1'b1;
      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // Asynchronous reset in the middle of HOLD with a buffered redirect.
      drive(1, 1, 0, 0, 32'h0, 1, 32'h700);
      @(posedge clk);
      #1;
      chk("pre-reset pending_valid", {31'b0, pending_valid}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("async pc", current_pc, 32'h0);
      chk("async pending_valid", {31'b0, pending_valid}, 32'd0);
      chk("async fetch_req", {31'b0, fetch_req}, 32'd0);
      chk("async redirect_taken", {31'b0, redirect_taken}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
      chk("async misalign_err", {31'b0, misalign_err}, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b1;
      apply(v(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0), "post-reset boot");
      apply(v(0, 1, 0, 1, 32'h103, 0, 32'h0, 32'h100, 1, 0, 1), "misaligned jump");
      apply(v(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h104, 0, 0, 1), "after misaligned jump");

      // Randomized traffic against the reference model.
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      m_mode = 0; m_pc = 32'h0; m_ppri = 0; m_ptgt = 32'h0; m_redir = 1'b0; m_mis = 1'b0;
      for (int c = 0; c < 600; c++) begin
         logic        s, r, e, j, b;
         logic [31:0] jt, bt;
         s  = ($urandom_range(3) == 0);
         r  = ($urandom_range(3) != 0);
         e  = ($urandom_range(15) == 0);
         j  = ($urandom_range(7) == 0);
         b  = ($urandom_range(5) == 0);
         jt = $urandom;
         bt = $urandom;
         drive(s, r, e, j, jt, b, bt);
         model_step(s, r, e, j, jt, b, bt);
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d pc", c), current_pc, m_pc);
         chk($sformatf("rnd%0d redirect_taken", c), {31'b0, redirect_taken}, {31'b0, m_redir});
         chk($sformatf("rnd%0d pending_valid", c), {31'b0, pending_valid},
             {31'b0, m_mode == 2});
         chk($sformatf("rnd%0d fetch_req", c), {31'b0, fetch_req}, {31'b0, m_mode != 0});
`ifdef PC_ALIGN_CHECK_EN
         chk($sformatf("rnd%0d misalign_err", c), {31'b0, misalign_err}, {31'b0, m_mis});
`endif
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
